// File: rtl/l2_seq_pkg.sv
// ============================================================================
// Module      : l2_seq_pkg
// Description : Shared state encodings, line-alignment helper and group mask
//               for the L2 refill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_seq_pkg;

    localparam int          c_line_ofs   = 6;
    localparam logic [7:0]  c_group_mask = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_WB_TRIG = 3'd2,
        ST_WB_WAIT = 3'd3,
        ST_RD_TRIG = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_DONE    = 3'd6,
        ST_FAULT   = 3'd7
    } seq_state_t;

    function automatic logic [31:0] align_line(input logic [31:0] addr, input int ofs);
        return addr & ~((32'd1 << ofs) - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_rr_arbiter.sv
// ============================================================================
// Module      : l2_rr_arbiter
// Description : Round-robin arbiter; search starts one past the last grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic [NUM_REQ-1:0]                         i_req,
    input  logic                                       i_advance,
    output logic [NUM_REQ-1:0]                         o_grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_grant_idx,
    output logic                                       o_grant_valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_sum         = '0;
        w_pos         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!o_grant_valid && i_req[w_pos]) begin
                o_grant_valid  = 1'b1;
                o_grant_idx    = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l2_refill_sequencer.sv
// ============================================================================
// Module      : l2_refill_sequencer
// Description : Services one L2 miss at a time: optional victim write-back,
//               refill, tag update; escalates load-manager faults.
//               Optional counters enabled by macro L2SEQ_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_refill_sequencer
    import l2_seq_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int LINE_OFS = c_line_ofs
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]    req_group,
    input  logic [NUM_REQ-1:0]      req_dirty,
    input  logic [32*NUM_REQ-1:0]   req_victim,
    output logic [NUM_REQ-1:0]      req_done,
    output logic                    req_err,
    output logic                    lm_wtrig,
    output logic                    lm_rtrig,
    output logic [31:0]             lm_addr,
    output logic [7:0]              lm_group,
    input  logic                    lm_finish,
    input  logic                    lm_fault,
    output logic                    tag_we,
    output logic [7:0]              tag_group,
    output logic [31:0]             tag_addr,
    output logic                    seq_busy,
`ifdef L2SEQ_STATS_EN
    output logic [31:0]             stat_miss,
    output logic [31:0]             stat_wb,
    output logic [7:0]              stat_fault,
`endif
    output logic                    seq_fault
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    seq_state_t          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [31:0]         r_addr;
    logic [31:0]         r_victim;
    logic [7:0]          r_group;
    logic                r_dirty;
    logic [NUM_REQ-1:0]  r_req_done;
    logic                r_req_err;
    logic                r_lm_wtrig;
    logic                r_lm_rtrig;
    logic [31:0]         r_lm_addr;
    logic [7:0]          r_lm_group;
    logic                r_tag_we;
    logic [7:0]          r_tag_group;
    logic [31:0]         r_tag_addr;
    logic                r_seq_busy;
    logic                r_seq_fault;

    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [IDX_W-1:0]    w_arb_idx;
    logic                w_arb_valid;
    logic                w_advance;

    assign w_advance = (r_state == ST_IDLE) && !lm_fault && w_arb_valid;

    l2_rr_arbiter #(
        .NUM_REQ       (NUM_REQ)
    ) u_arb (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_req         (req_valid),
        .i_advance     (w_advance),
        .o_grant       (w_arb_grant),
        .o_grant_idx   (w_arb_idx),
        .o_grant_valid (w_arb_valid)
    );

`ifdef L2SEQ_STATS_EN
    logic [31:0] r_stat_miss;
    logic [31:0] r_stat_wb;
    logic [7:0]  r_stat_fault;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_addr      <= '0;
            r_victim    <= '0;
            r_group     <= '0;
            r_dirty     <= 1'b0;
            r_req_done  <= '0;
            r_req_err   <= 1'b0;
            r_lm_wtrig  <= 1'b0;
            r_lm_rtrig  <= 1'b0;
            r_lm_addr   <= '0;
            r_lm_group  <= '0;
            r_tag_we    <= 1'b0;
            r_tag_group <= '0;
            r_tag_addr  <= '0;
            r_seq_busy  <= 1'b0;
            r_seq_fault <= 1'b0;
`ifdef L2SEQ_STATS_EN
            r_stat_miss  <= '0;
            r_stat_wb    <= '0;
            r_stat_fault <= '0;
`endif
        end else begin
            r_lm_wtrig <= 1'b0;
            r_lm_rtrig <= 1'b0;
            r_req_done <= '0;
            r_req_err  <= 1'b0;
            r_tag_we   <= 1'b0;
            // A fault wins over a same-cycle finish; a miss already in DONE was completed cleanly.
            if (lm_fault && (r_state != ST_IDLE) && (r_state != ST_FAULT)) begin
                if (r_state != ST_DONE) begin
                    r_req_done <= r_grant;
                    r_req_err  <= 1'b1;
                end
                r_seq_fault <= 1'b1;
                r_state     <= ST_FAULT;
`ifdef L2SEQ_STATS_EN
                if (r_stat_fault != '1) r_stat_fault <= r_stat_fault + 8'd1;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (lm_fault) begin
                            r_seq_fault <= 1'b1;
                            r_seq_busy  <= 1'b1;
                            r_state     <= ST_FAULT;
`ifdef L2SEQ_STATS_EN
                            if (r_stat_fault != '1) r_stat_fault <= r_stat_fault + 8'd1;
`endif
                        end else if (w_arb_valid) begin
                            r_grant    <= w_arb_grant;
                            r_addr     <= req_addr[32*w_arb_idx +: 32];
                            r_victim   <= req_victim[32*w_arb_idx +: 32];
                            r_group    <= req_group[8*w_arb_idx +: 8];
                            r_dirty    <= req_dirty[w_arb_idx];
                            r_seq_busy <= 1'b1;
                            r_state    <= ST_GRANT;
                        end
                    end
                    ST_GRANT: begin
                        r_lm_group <= r_group & c_group_mask;
                        if (r_dirty) begin
                            r_lm_wtrig <= 1'b1;
                            r_lm_addr  <= align_line(r_victim, LINE_OFS);
                            r_state    <= ST_WB_TRIG;
                        end else begin
                            r_lm_rtrig <= 1'b1;
                            r_lm_addr  <= align_line(r_addr, LINE_OFS);
                            r_state    <= ST_RD_TRIG;
                        end
                    end
                    ST_WB_TRIG: r_state <= ST_WB_WAIT;
                    ST_WB_WAIT: begin
                        if (lm_finish) begin
                            r_lm_rtrig <= 1'b1;
                            r_lm_addr  <= align_line(r_addr, LINE_OFS);
                            r_state    <= ST_RD_TRIG;
`ifdef L2SEQ_STATS_EN
                            if (r_stat_wb != '1) r_stat_wb <= r_stat_wb + 32'd1;
`endif
                        end
                    end
                    ST_RD_TRIG: r_state <= ST_RD_WAIT;
                    ST_RD_WAIT: begin
                        if (lm_finish) begin
                            r_req_done  <= r_grant;
                            r_tag_we    <= 1'b1;
                            r_tag_addr  <= align_line(r_addr, LINE_OFS);
                            r_tag_group <= r_group;
                            r_state     <= ST_DONE;
`ifdef L2SEQ_STATS_EN
                            if (r_stat_miss != '1) r_stat_miss <= r_stat_miss + 32'd1;
`endif
                        end
                    end
                    ST_DONE: begin
                        r_seq_busy <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    ST_FAULT: r_state <= ST_FAULT;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign req_done  = r_req_done;
    assign req_err   = r_req_err;
    assign lm_wtrig  = r_lm_wtrig;
    assign lm_rtrig  = r_lm_rtrig;
    assign lm_addr   = r_lm_addr;
    assign lm_group  = r_lm_group;
    assign tag_we    = r_tag_we;
    assign tag_group = r_tag_group;
    assign tag_addr  = r_tag_addr;
    assign seq_busy  = r_seq_busy;
    assign seq_fault = r_seq_fault;
`ifdef L2SEQ_STATS_EN
    assign stat_miss  = r_stat_miss;
    assign stat_wb    = r_stat_wb;
    assign stat_fault = r_stat_fault;
`endif

endmodule

`default_nettype wire
